// File: rtl/uart_tx_buffer_pkg.sv
// uart_txbuf_pkg: shared definitions for the UART transmit buffer.
//   - register word offsets decoded from Address[3:2]
//   - STATUS register bit positions
//   - drain FSM state encoding and the WAIT_HI handshake timeout
package uart_txbuf_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_IRQ    = 2'd3;

   // STATUS layout: {.., overflow, count[ADDR_W:0], full, empty, busy}
   localparam int unsigned STS_BUSY      = 0;
   localparam int unsigned STS_EMPTY     = 1;
   localparam int unsigned STS_FULL      = 2;
   localparam int unsigned STS_COUNT_LSB = 3;

   localparam int unsigned WAIT_HI_TIMEOUT = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } drain_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: core-side memory-mapped bus for the UART transmit buffer.
//   Address  byte address from the decoder (only [3:2] decoded)
//   DataIn   write data from the core
//   DataOut  registered read data from the buffer
//   Select   chip select
//   Write    write strike, qualified by Select
// modport master: core/decoder side; modport slave: the buffer.
interface uart_tx_buffer_if #(
   parameter int unsigned DATA_LENGTH = 32
);
   logic [31:0]            Address;
   logic [DATA_LENGTH-1:0] DataIn;
   logic [DATA_LENGTH-1:0] DataOut;
   logic                   Select;
   logic                   Write;

   modport master (output Address, DataIn, Select, Write, input DataOut);
   modport slave  (input Address, DataIn, Select, Write, output DataOut);
endinterface

// File: rtl/uart_tx_buffer_fifo.sv
// sync_fifo_param: circular FIFO with push, pop and flush.
//   clk/rst   clock, asynchronous active-high reset
//   push      write wdata (accepted when not full, or when popping too)
//   pop       drop head (ignored when empty); rdata shows the head
//   flush     zero pointers and count; overrides push/pop
//   full, empty, count[ADDR_W:0]
module sync_fifo_param #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == (ADDR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so push is legal while full.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: memory-mapped transmit FIFO feeding a UART serializer.
//   clk, rst     clock, asynchronous active-high reset
//   bus          uart_tx_buffer_if.slave (Address, DataIn, DataOut, Select, Write)
//   tx_data      byte presented to the serializer (holds last popped byte)
//   tx_start     one-cycle start pulse
//   tx_busy      serializer busy, high for the whole frame
//   irq_tx_low   (only with UART_TXBUF_IRQ_EN) level, high while enabled and
//                count <= threshold
// Registers: 0 DATA (push), 1 STATUS, 2 CTRL (bit0 flush), 3 IRQ config or
// reserved.
module uart_tx_buffer
   import uart_txbuf_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned DATA_LENGTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_tx_buffer_if.slave      bus,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
`ifdef UART_TXBUF_IRQ_EN
   output logic                 irq_tx_low,
`endif
   input  logic                 tx_busy
);

   localparam int unsigned STS_OVF = STS_COUNT_LSB + ADDR_W + 1;

   drain_state_e           state_q, state_d;
   logic [2:0]             timer_q, timer_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic [DATA_LENGTH-1:0] dataout_q, dataout_d;
   logic                   overflow_q, overflow_d;

   logic [1:0]             off;
   logic                   rd_en, wr_data, wr_flush, pop;
   logic [7:0]             fifo_rdata;
   logic                   full, empty;
   logic [ADDR_W:0]        count;
   logic [DATA_LENGTH-1:0] status;
   logic                   unused_bits;

   assign off      = bus.Address[3:2];
   assign rd_en    = bus.Select & ~bus.Write;
   assign wr_data  = bus.Select & bus.Write & (off == OFF_DATA);
   assign wr_flush = bus.Select & bus.Write & (off == OFF_CTRL) & bus.DataIn[0];

   assign unused_bits = ^{bus.Address[31:4], bus.Address[1:0],
                          bus.DataIn[DATA_LENGTH-1:1]};

   sync_fifo_param #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .pop   (pop),
      .flush (wr_flush),
      .wdata (bus.DataIn[7:0]),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Drain FSM. A start is suppressed in a flush cycle so the discarded head
   // is never sent.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !tx_busy && !wr_flush) begin
               pop        = 1'b1;
               tx_data_d  = fifo_rdata;
               tx_start_d = 1'b1;
               timer_d    = '0;
               state_d    = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) begin
               state_d = WAIT_LO;
            end else if (timer_q == 3'(WAIT_HI_TIMEOUT - 1)) begin
               state_d = WAIT_LO;
            end else begin
               timer_d = timer_q + 3'd1;
            end
         end
         WAIT_LO: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      status                  = '0;
      status[STS_BUSY]        = (state_q != IDLE);
      status[STS_EMPTY]       = empty;
      status[STS_FULL]        = full;
      status[STS_COUNT_LSB +: ADDR_W+1] = count;
      status[STS_OVF]         = overflow_q;
   end

`ifdef UART_TXBUF_IRQ_EN
   logic [ADDR_W:0] irq_cfg_q, irq_cfg_d;
   logic            irq_q, irq_d;

   always_comb begin
      irq_cfg_d = irq_cfg_q;
      if (bus.Select && bus.Write && off == OFF_IRQ)
         irq_cfg_d = bus.DataIn[ADDR_W:0];
      irq_d = irq_cfg_q[0] & (count <= {1'b0, irq_cfg_q[ADDR_W:1]});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_cfg_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         irq_cfg_q <= irq_cfg_d;
         irq_q     <= irq_d;
      end
   end

   assign irq_tx_low = irq_q;
`endif

   always_comb begin
      dataout_d  = dataout_q;
      overflow_d = overflow_q;
      if (rd_en) begin
         case (off)
            OFF_STATUS: dataout_d = status;
`ifdef UART_TXBUF_IRQ_EN
            OFF_IRQ:    dataout_d = DATA_LENGTH'(irq_cfg_q);
`endif
            default:    dataout_d = '0;
         endcase
         if (off == OFF_STATUS) overflow_d = 1'b0;
      end
      if (wr_data && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         dataout_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         dataout_q  <= dataout_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign bus.DataOut = dataout_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized self-checking bench for uart_tx_buffer.
// A serializer model answers tx_start with a busy frame; a byte queue models
// the FIFO contents and the expected transmit order. Build with
// +define+UART_TXBUF_IRQ_EN to exercise the low-water interrupt.
module tb_uart_tx_buffer;

   localparam int DEPTH = 16;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
`ifdef UART_TXBUF_IRQ_EN
   logic       irq_tx_low;
`endif

   uart_tx_buffer_if #(.DATA_LENGTH(32)) bus ();

   uart_tx_buffer #(
      .DEPTH       (16),
      .ADDR_W      (4),
      .DATA_LENGTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
`ifdef UART_TXBUF_IRQ_EN
      .irq_tx_low (irq_tx_low),
`endif
      .tx_busy    (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // serializer model state
   bit  hold_busy    = 1'b0;
   bit  ignore_start = 1'b0;
   int  ser_len      = 20;
   int  ser_left     = 0;
   int  cyc          = 0;
   int  start_cnt    = 0;
   int  last_cyc     = 0;
   int  last_gap     = 0;
   int  req_gap      = 0;
   bit  prev_start   = 1'b0;
   bit  model_ovf    = 1'b0;
   logic [7:0] model_q[$];

   assign tx_busy = hold_busy | (ser_left != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_word(input int size, input bit ovf, input bit busy);
      logic [31:0] w;
      w = 32'(ovf) << 8;
      w = w | (32'(size) << 3);
      if (size == DEPTH) w = w | 32'h4;
      if (size == 0)     w = w | 32'h2;
      if (busy)          w = w | 32'h1;
      return w;
   endfunction

   // Serializer + transmit monitor, evaluated away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (ser_left > 0) ser_left--;
         if (tx_start === 1'b1) begin
            check("tx_pulse_width", 32'(prev_start), 32'd0);
            if (start_cnt > 0) begin
               last_gap = cyc - last_cyc;
               if (req_gap > 0) check("tx_gap_ok", 32'(last_gap >= req_gap), 32'd1);
            end
            if (model_q.size() == 0) begin
               check("tx_unexpected", 32'd1, 32'd0);
            end else begin
               check("tx_data", 32'(tx_data), 32'(model_q.pop_front()));
            end
            start_cnt++;
            last_cyc = cyc;
            if (!ignore_start) begin
               ser_left = ser_len;
               req_gap  = ser_len + 2;
            end else begin
               req_gap = 0;
            end
         end
         prev_start = (tx_start === 1'b1);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
      @(negedge clk);
      bus.Select  = 1'b1;
      bus.Write   = 1'b1;
      bus.Address = {28'd0, off, 2'b00};
      bus.DataIn  = data;
      if (off == 2'd0) begin
         if (model_q.size() < DEPTH) model_q.push_back(data[7:0]);
         else model_ovf = 1'b1;
      end
      if (off == 2'd2 && data[0]) model_q.delete();
      @(negedge clk);
      bus.Select = 1'b0;
      bus.Write  = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
      @(negedge clk);
      bus.Select  = 1'b1;
      bus.Write   = 1'b0;
      bus.Address = {28'd0, off, 2'b00};
      @(negedge clk);
      bus.Select = 1'b0;
      data = bus.DataOut;
      if (off == 2'd1) model_ovf = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k;
      k = 0;
      while (start_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("start_timeout", 32'(start_cnt >= n), 32'd1);
   endtask

   logic [31:0] rd;
   int          base;
   logic [7:0]  b;

   initial begin
      rst         = 1'b1;
      bus.Select  = 1'b0;
      bus.Write   = 1'b0;
      bus.Address = '0;
      bus.DataIn  = '0;
      cycles(3);
      rst = 1'b0;
      cycles(1);

      // reset state
      check("rst_dataout", bus.DataOut, 32'h0);
      check("rst_tx_start", 32'(tx_start), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      bus_read(2'd1, rd);
      check("rst_status", rd, 32'h0000_0002);

      // three bytes, 20-cycle frames
      ser_len = 20;
      base = start_cnt;
      bus_write(2'd0, 32'h41);
      bus_write(2'd0, 32'h42);
      bus_write(2'd0, 32'h43);
      wait_starts(base + 3, 200);
      cycles(25);
      bus_read(2'd1, rd);
      check("drain3_status", rd, status_word(0, 0, 0));

      // data/ctrl reads return zero
      bus_read(2'd0, rd);
      check("read_data_zero", rd, 32'h0);
      bus_read(2'd2, rd);
      check("read_ctrl_zero", rd, 32'h0);

      // fill while serializer busy, 17th byte overflows
      hold_busy = 1'b1;
      for (int i = 0; i < 17; i++) bus_write(2'd0, 32'($urandom_range(0, 255)));
      check("ovf_model", 32'(model_ovf), 32'd1);
      bus_read(2'd1, rd);
      check("full_status", rd, status_word(DEPTH, 1, 0));
      bus_read(2'd1, rd);
      check("ovf_cleared", rd, status_word(DEPTH, 0, 0));

      // push while full in the same cycle the FSM pops
      base = start_cnt;
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      hold_busy   = 1'b0;
      bus.Select  = 1'b1;
      bus.Write   = 1'b1;
      bus.Address = 32'h0;
      bus.DataIn  = {24'd0, b};
      model_q.push_back(b);
      @(negedge clk);
      bus.Select = 1'b0;
      bus.Write  = 1'b0;
      cycles(2);
      check("popush_started", 32'(start_cnt), 32'(base + 1));
      bus_read(2'd1, rd);
      check("popush_status", rd, status_word(DEPTH, 0, 1));
      wait_starts(base + 17, 17 * 30);
      cycles(25);
      bus_read(2'd1, rd);
      check("popush_drained", rd, status_word(0, 0, 0));

      // flush mid-drain with 5 bytes queued
      base = start_cnt;
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'($urandom_range(0, 255)));
      wait_starts(base + 1, 40);
      cycles(3);
      bus_write(2'd2, 32'h1);
      bus_read(2'd1, rd);
      check("flush_status", rd, status_word(0, 0, 1));
      cycles(60);
      check("flush_no_start", 32'(start_cnt), 32'(base + 1));
      bus_read(2'd1, rd);
      check("flush_idle", rd, status_word(0, 0, 0));

      // lost handshake: serializer never raises busy
      ignore_start = 1'b1;
      base = start_cnt;
      bus_write(2'd0, 32'($urandom_range(0, 255)));
      bus_write(2'd0, 32'($urandom_range(0, 255)));
      wait_starts(base + 2, 60);
      check("hs_timeout_gap", 32'(last_gap >= 5 && last_gap <= 7), 32'd1);
      ignore_start = 1'b0;
      cycles(10);
      bus_read(2'd1, rd);
      check("hs_idle", rd, status_word(0, 0, 0));

      // random bursts with random frame lengths
      for (int r = 0; r < 6; r++) begin
         int n;
         ser_len = $urandom_range(3, 30);
         n = $urandom_range(1, 6);
         base = start_cnt;
         for (int i = 0; i < n; i++) bus_write(2'd0, 32'($urandom_range(0, 255)));
         wait_starts(base + n, n * 40 + 20);
         cycles(ser_len + 6);
         bus_read(2'd1, rd);
         check("burst_status", rd, status_word(0, 0, 0));
      end
      ser_len = 20;

`ifdef UART_TXBUF_IRQ_EN
      // low-water interrupt, threshold 2
      check("irq_reset", 32'(irq_tx_low), 32'd0);
      bus_write(2'd3, 32'h5);
      bus_read(2'd3, rd);
      check("irq_cfg_read", rd, 32'h5);
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'($urandom_range(0, 255)));
      cycles(3);
      check("irq_low_5", 32'(irq_tx_low), 32'd0);
      base = start_cnt;
      hold_busy = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         wait_starts(base + k, 40);
         cycles(4);
         check("irq_level", 32'(irq_tx_low), 32'(model_q.size() <= 2));
      end
      cycles(30);
      check("irq_empty", 32'(irq_tx_low), 32'd1);
`else
      bus_write(2'd3, 32'h1F);
      bus_read(2'd3, rd);
      check("reserved_read", rd, 32'h0);
      bus_read(2'd1, rd);
      check("reserved_status", rd, status_word(0, 0, 0));
`endif

      check("model_empty", 32'(model_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, wanted finished");
      $fatal(1, "timeout");
   end

endmodule
